calibration_sequencer: RTL
==========================

Name: calibration_sequencer

Overview:
- Sequences LED-ID calibration. Drives the bit-select of the LED ID display block and a camera-capture handshake.
- Per run: one blank baseline capture, then one capture per LED address bit, LSB first.
- Sits between the user start/abort controls, the ID display block (bit select, frame-valid flag) and the camera frame-capture block.

Parameters:
- NUM_LEDS, 50, number of LEDs on the strip; NUM_BITS = $clog2(NUM_LEDS) (derived localparam, 6 at default).
- BIT_NUM_WIDTH, 3, width of the bit index; must satisfy 2**BIT_NUM_WIDTH >= NUM_BITS.
- SETTLE_CYCLES, 1000, cycles to wait after the display is valid before requesting capture (covers camera exposure lag).
- TIMEOUT_CYCLES, 50_000_000, maximum cycles spent in any wait state before ERROR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; a rising edge in IDLE, DONE or ERROR begins a run
- abort  in  1  level; a rising edge in any active state returns to IDLE
- displayed_frame_valid  in  1  display block has shown at least one full valid frame for the current bit
- capture_ack  in  1  camera block accepted the capture request; 1-cycle pulse
- bit_num  out  BIT_NUM_WIDTH  address bit the display must show
- display_blank  out  1  display must drive all LEDs off (baseline frame)
- display_restart  out  1  1-cycle pulse; display block clears its frame-valid tracking
- capture_req  out  1  request a camera frame capture
- capture_is_baseline  out  1  qualifies capture_req: 1 = baseline frame, 0 = bit frame for bit_num
- busy  out  1  high in every state except IDLE, DONE and ERROR
- done  out  1  high in DONE
- error  out  1  high in ERROR

Behaviour:
- Reset (rst=1 on a clock edge): state=IDLE, bit_num=0, display_blank=0, display_restart=0, capture_req=0, capture_is_baseline=0, busy=0, done=0, error=0. Wait counter=0. Start/abort edge detectors load the current input levels, so an input held high through reset does not generate an edge.
- Edge detection: registered previous value of start and abort; edge = input & ~prev.
- States and transitions:
  - IDLE: on start edge -> BLANK_SETUP.
  - BLANK_SETUP (1 cycle): display_blank=1, display_restart=1, capture_is_baseline=1, wait counter cleared -> WAIT_VALID.
  - SELECT (1 cycle): display_blank=0, display_restart=1, capture_is_baseline=0, bit_num unchanged, wait counter cleared -> WAIT_VALID.
  - WAIT_VALID: when displayed_frame_valid=1 -> SETTLE, counter cleared. displayed_frame_valid is ignored in the cycle display_restart is high.
  - SETTLE: count SETTLE_CYCLES cycles -> CAPTURE. SETTLE_CYCLES=0 means go straight to CAPTURE.
  - CAPTURE: capture_req=1 from the first CAPTURE cycle until the cycle in which capture_ack=1 is sampled. capture_req=0 on the following edge.
  - On ack: if baseline, clear capture_is_baseline, keep bit_num=0 -> SELECT. Else if bit_num==NUM_BITS-1 -> DONE. Else increment bit_num -> SELECT.
  - DONE: done=1, all display/capture outputs idle; start edge -> BLANK_SETUP with bit_num=0.
  - ERROR: error=1, same exits as DONE.
- Timeout: in WAIT_VALID or CAPTURE, if the wait counter reaches TIMEOUT_CYCLES-1 without the awaited event -> ERROR, capture_req drops. If the event and the timeout occur in the same cycle, the event wins.
- Abort:
  - An abort edge in any busy state has priority over every other transition in that cycle. Next state IDLE; all outputs return to reset values except bit_num, which is cleared.
  - If abort and capture_ack arrive together, the ack is dropped and nothing advances.
  - Abort in IDLE, DONE or ERROR has no effect.
- start edges while busy are ignored.
- capture_ack outside CAPTURE is ignored.
- Latency: start edge to the first display_restart pulse is 1 cycle. Ack to the next display_restart is 1 cycle.
- Counter width is $clog2(max(SETTLE_CYCLES, TIMEOUT_CYCLES)+1). The counter saturates and never wraps.
- bit_num never exceeds NUM_BITS-1; it holds its value through SETTLE and CAPTURE.

Test Plan:
- Full run, NUM_LEDS=50, SETTLE_CYCLES=4, frame_valid returned 3 cycles after each restart, ack 2 cycles after req -> 7 capture_req bursts (1 baseline + bit_num 0..5), done=1 after 6th bit ack, busy=0.
- Req/ack timing: ack delayed 10 cycles -> capture_req held exactly until the ack cycle, low the next cycle, exactly one SELECT per ack; stray ack in SETTLE ignored.
- Timeout with TIMEOUT_CYCLES=16: displayed_frame_valid never asserted -> error=1 exactly 16 cycles after WAIT_VALID entry, capture_req never asserted; next start edge restarts at baseline.
- Abort during CAPTURE with simultaneous capture_ack at bit_num=3 -> IDLE next cycle, bit_num=0, capture_req=0, no done.
- start held high through rst deassert -> stays IDLE; toggle low/high -> run begins with display_restart 1 cycle after the edge. start edge mid-run does nothing.
- SETTLE_CYCLES=0 and NUM_LEDS=2 (NUM_BITS=1) -> baseline plus a single bit-0 capture, capture_req in the cycle after frame_valid, then done.

Source files
------------

// File: rtl/calibration_sequencer.sv
// rtl/calibration_sequencer.sv - LED-ID calibration sequencer: baseline capture then one capture per address bit
// Drives the ID display bit select and the camera capture handshake; all outputs are registered.
module calibration_sequencer #(
   parameter int NUM_LEDS       = 50,
   parameter int BIT_NUM_WIDTH  = 3,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     displayed_frame_valid,
   input  logic                     capture_ack,
   output logic [BIT_NUM_WIDTH-1:0] bit_num,
   output logic                     display_blank,
   output logic                     display_restart,
   output logic                     capture_req,
   output logic                     capture_is_baseline,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);
   localparam int NUM_BITS  = $clog2(NUM_LEDS);
   localparam int CNT_LIMIT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [BIT_NUM_WIDTH-1:0] LAST_BIT = BIT_NUM_WIDTH'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BLANK_SETUP,
      S_SELECT,
      S_WAIT_VALID,
      S_SETTLE,
      S_CAPTURE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             start_q;
   logic             abort_q;
   logic             start_edge;
   logic             abort_edge;
   logic             active;

   assign start_edge = start & ~start_q;
   assign abort_edge = abort & ~abort_q;
   assign active     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
   // Saturating increment: the counter must never wrap back into a "fresh" value.
   assign cnt_next   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         bit_num             <= '0;
         display_blank       <= 1'b0;
         display_restart     <= 1'b0;
         capture_req         <= 1'b0;
         capture_is_baseline <= 1'b0;
         busy                <= 1'b0;
         done                <= 1'b0;
         error               <= 1'b0;
         wait_cnt            <= '0;
         start_q             <= start;
         abort_q             <= abort;
      end else begin
         start_q         <= start;
         abort_q         <= abort;
         display_restart <= 1'b0;
         if (abort_edge && active) begin
            state               <= S_IDLE;
            bit_num             <= '0;
            display_blank       <= 1'b0;
            capture_req         <= 1'b0;
            capture_is_baseline <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            wait_cnt            <= '0;
         end else begin
            case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (start_edge) begin
                     state               <= S_BLANK_SETUP;
                     bit_num             <= '0;
                     display_blank       <= 1'b1;
                     display_restart     <= 1'b1;
                     capture_is_baseline <= 1'b1;
                     busy                <= 1'b1;
                     done                <= 1'b0;
                     error               <= 1'b0;
                     wait_cnt            <= '0;
                  end
               end
               S_BLANK_SETUP, S_SELECT: begin
                  state    <= S_WAIT_VALID;
                  wait_cnt <= '0;
               end
               S_WAIT_VALID: begin
                  if (displayed_frame_valid) begin
                     wait_cnt <= '0;
                     if (SETTLE_CYCLES == 0) begin
                        state       <= S_CAPTURE;
                        capture_req <= 1'b1;
                     end else begin
                        state <= S_SETTLE;
                     end
                  end else if (wait_cnt == TIMEOUT_LAST) begin
                     state               <= S_ERROR;
                     error               <= 1'b1;
                     busy                <= 1'b0;
                     display_blank       <= 1'b0;
                     capture_is_baseline <= 1'b0;
                  end else begin
                     wait_cnt <= cnt_next;
                  end
               end
               S_SETTLE: begin
                  if (wait_cnt == SETTLE_LAST) begin
                     state       <= S_CAPTURE;
                     capture_req <= 1'b1;
                     wait_cnt    <= '0;
                  end else begin
                     wait_cnt <= cnt_next;
                  end
               end
               S_CAPTURE: begin
                  // An ack in the same cycle as the timeout still counts as a capture.
                  if (capture_ack) begin
                     capture_req <= 1'b0;
                     wait_cnt    <= '0;
                     if (capture_is_baseline) begin
                        capture_is_baseline <= 1'b0;
                        display_blank       <= 1'b0;
                        display_restart     <= 1'b1;
                        state               <= S_SELECT;
                     end else if (bit_num == LAST_BIT) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        bit_num         <= bit_num + 1'b1;
                        display_restart <= 1'b1;
                        state           <= S_SELECT;
                     end
                  end else if (wait_cnt == TIMEOUT_LAST) begin
                     state               <= S_ERROR;
                     error               <= 1'b1;
                     busy                <= 1'b0;
                     capture_req         <= 1'b0;
                     display_blank       <= 1'b0;
                     capture_is_baseline <= 1'b0;
                  end else begin
                     wait_cnt <= cnt_next;
                  end
               end
            endcase
         end
      end
   end
endmodule
